// File: rtl/inst_fetcher.sv
// Instruction-fetch front end: holds the PC, looks it up in a direct-mapped one-word-per-line
// I-cache and falls back to single-word memory fetches. Define ICACHE_EN to build the cache.
module inst_fetcher #(
    parameter int ICACHE_IDX_W = 6,
    parameter int RESULT_GUARD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear_flag_in,
    input  logic [31:0] clear_pc_in,
    output logic        mc_fetch_enable_out,
    output logic [31:0] mc_addr_out,
    input  logic        mc_result_enable_in,
    input  logic [31:0] mc_data_in,
    input  logic        iq_full_in,
    output logic        iq_enable_out,
    output logic [31:0] iq_inst_out,
    output logic [31:0] iq_pc_out
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        DELIVER
    } state_t;

    localparam logic [2:0] GUARD_CNT = (RESULT_GUARD > 7) ? 3'd7 : 3'(RESULT_GUARD);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        mc_fetch_q, mc_fetch_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic        iq_en_q, iq_en_d;
    logic [31:0] iq_inst_q, iq_inst_d;
    logic [31:0] iq_pc_q, iq_pc_d;

    logic        hit;
    logic [31:0] line_data;
    logic        cache_we;

`ifdef ICACHE_EN
    localparam int TAG_W = 32 - ICACHE_IDX_W - 2;
    localparam int LINES = 1 << ICACHE_IDX_W;

    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES];
    logic [ICACHE_IDX_W-1:0] idx;
    logic [TAG_W-1:0]        tag;

    // pc_q equals the outstanding fetch address in WAIT_MEM, so it indexes both lookup and fill.
    assign idx       = pc_q[ICACHE_IDX_W+1:2];
    assign tag       = pc_q[31:ICACHE_IDX_W+2];
    assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
    assign line_data = data_mem[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (cache_we) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cache_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mc_data_in;
        end
    end
`else
    logic [31:0] unused_cfg;

    assign hit        = 1'b0;
    assign line_data  = '0;
    assign unused_cfg = {31'd0, cache_we} ^ 32'(ICACHE_IDX_W);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wait_cnt_d = wait_cnt_q;
        hold_d     = hold_q;
        mc_fetch_d = 1'b0;
        mc_addr_d  = mc_addr_q;
        iq_en_d    = 1'b0;
        iq_inst_d  = iq_inst_q;
        iq_pc_d    = iq_pc_q;
        cache_we   = 1'b0;

        if (rdy) begin
            // A clear beats everything, including a result landing in the same cycle.
            if (clear_flag_in) begin
                pc_d    = clear_pc_in;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!iq_full_in) begin
                            if (hit) begin
                                iq_en_d   = 1'b1;
                                iq_inst_d = line_data;
                                iq_pc_d   = pc_q;
                                pc_d      = pc_q + 32'd4;
                            end else begin
                                mc_fetch_d = 1'b1;
                                mc_addr_d  = pc_q;
                                wait_cnt_d = 3'd0;
                                state_d    = WAIT_MEM;
                            end
                        end
                    end
                    WAIT_MEM: begin
                        if (wait_cnt_q != 3'd7) begin
                            wait_cnt_d = wait_cnt_q + 3'd1;
                        end
                        if (mc_result_enable_in && (wait_cnt_q >= GUARD_CNT)) begin
                            cache_we = 1'b1;
                            hold_d   = mc_data_in;
                            state_d  = DELIVER;
                        end
                    end
                    DELIVER: begin
                        if (!iq_full_in) begin
                            iq_en_d   = 1'b1;
                            iq_inst_d = hold_q;
                            iq_pc_d   = pc_q;
                            pc_d      = pc_q + 32'd4;
                            state_d   = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            wait_cnt_q <= '0;
            hold_q     <= '0;
            mc_fetch_q <= 1'b0;
            mc_addr_q  <= '0;
            iq_en_q    <= 1'b0;
            iq_inst_q  <= '0;
            iq_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wait_cnt_q <= wait_cnt_d;
            hold_q     <= hold_d;
            mc_fetch_q <= mc_fetch_d;
            mc_addr_q  <= mc_addr_d;
            iq_en_q    <= iq_en_d;
            iq_inst_q  <= iq_inst_d;
            iq_pc_q    <= iq_pc_d;
        end
    end

    assign mc_fetch_enable_out = mc_fetch_q;
    assign mc_addr_out         = mc_addr_q;
    assign iq_enable_out       = iq_en_q;
    assign iq_inst_out         = iq_inst_q;
    assign iq_pc_out           = iq_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: a word-stream scoreboard plus an address-level cache model
// and a randomized-latency memory responder (cache expectations follow the ICACHE_EN define).
module tb_inst_fetcher;

    localparam int IDX_W = 6;
    localparam int GUARD = 2;
    localparam int LINES = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear_flag_in;
    logic [31:0] clear_pc_in;
    logic        mc_fetch_enable_out;
    logic [31:0] mc_addr_out;
    logic        mc_result_enable_in;
    logic [31:0] mc_data_in;
    logic        iq_full_in;
    logic        iq_enable_out;
    logic [31:0] iq_inst_out;
    logic [31:0] iq_pc_out;

    int checks = 0;
    int failures = 0;

    logic [31:0] modelPc;
    bit          reqSeen;
    int          pendingCnt;
    logic [31:0] pendingAddr;
    bit          resultLegit;
    logic [31:0] resultAddr;
    bit          staleHold;
    int          fixedLat = 0;
    int          reqCount = 0;
    int          pushCount = 0;
    bit          cacheValid [LINES];
    logic [31:0] cacheAddr  [LINES];

    always #5 clk = ~clk;

    inst_fetcher #(
        .ICACHE_IDX_W(IDX_W),
        .RESULT_GUARD(GUARD)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .clear_flag_in      (clear_flag_in),
        .clear_pc_in        (clear_pc_in),
        .mc_fetch_enable_out(mc_fetch_enable_out),
        .mc_addr_out        (mc_addr_out),
        .mc_result_enable_in(mc_result_enable_in),
        .mc_data_in         (mc_data_in),
        .iq_full_in         (iq_full_in),
        .iq_enable_out      (iq_enable_out),
        .iq_inst_out        (iq_inst_out),
        .iq_pc_out          (iq_pc_out)
    );

    // Memory image: address 0 holds 0x00000013 (a nop), everything else is a scrambled address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        bit h;
        h = cacheValid[a[IDX_W+1:2]] && (cacheAddr[a[IDX_W+1:2]] == a);
`ifdef ICACHE_EN
        return h;
`else
        return h & 1'b0;
`endif
    endfunction

    task automatic modelReset();
        modelPc     = 32'd0;
        reqSeen     = 1'b0;
        pendingCnt  = 0;
        resultLegit = 1'b0;
        staleHold   = 1'b0;
        for (int i = 0; i < LINES; i++) cacheValid[i] = 1'b0;
    endtask

    // One clock: observe the edge's inputs, score the outputs, then play the memory controller.
    task automatic step();
        logic        wasClear, wasFull, wasResult, wasRdy;
        logic [31:0] wasClearPc;
        @(posedge clk);
        wasClear   = clear_flag_in;
        wasClearPc = clear_pc_in;
        wasFull    = iq_full_in;
        wasResult  = mc_result_enable_in;
        wasRdy     = rdy;
        #1;
        if (wasRdy && wasResult && resultLegit && !wasClear) begin
            cacheValid[resultAddr[IDX_W+1:2]] = 1'b1;
            cacheAddr[resultAddr[IDX_W+1:2]]  = resultAddr;
        end
        resultLegit = 1'b0;
        if (staleHold) begin
            staleHold = 1'b0;
        end else begin
            mc_result_enable_in = 1'b0;
            mc_data_in          = $urandom;
        end
        if (wasRdy && wasClear) begin
            modelPc    = wasClearPc;
            reqSeen    = 1'b0;
            pendingCnt = 0;
            checks++;
            if (iq_enable_out !== 1'b0 || mc_fetch_enable_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL clear_no_pulse: got push=%b fetch=%b expected 0 0", iq_enable_out, mc_fetch_enable_out);
            end
        end
        if (iq_enable_out === 1'b1) begin
            pushCount++;
            checks++;
            if (wasFull !== 1'b0) begin
                failures++;
                $display("[TB] FAIL push_while_full: got push with iq_full_in=%b expected no push", wasFull);
            end
            checks++;
            if (iq_pc_out !== modelPc) begin
                failures++;
                $display("[TB] FAIL push_pc: got %h expected %h", iq_pc_out, modelPc);
            end
            checks++;
            if (iq_inst_out !== memWord(modelPc)) begin
                failures++;
                $display("[TB] FAIL push_inst: got %h expected %h", iq_inst_out, memWord(modelPc));
            end
            if (!reqSeen) begin
                checks++;
                if (modelHit(modelPc) !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL push_without_fetch: got push of uncached pc %h expected a fetch first", modelPc);
                end
            end
            modelPc = modelPc + 32'd4;
            reqSeen = 1'b0;
        end
        if (mc_fetch_enable_out === 1'b1) begin
            reqCount++;
            checks++;
            if (mc_addr_out !== modelPc) begin
                failures++;
                $display("[TB] FAIL fetch_addr: got %h expected %h", mc_addr_out, modelPc);
            end
`ifdef ICACHE_EN
            checks++;
            if (modelHit(modelPc) !== 1'b0) begin
                failures++;
                $display("[TB] FAIL spurious_fetch: got fetch of cached pc %h expected a hit", modelPc);
            end
`endif
            reqSeen     = 1'b1;
            pendingAddr = mc_addr_out;
            pendingCnt  = (fixedLat > 0) ? fixedLat : int'($urandom_range(2, 5));
        end else if (pendingCnt > 0) begin
            pendingCnt--;
            if (pendingCnt == 0) begin
                mc_result_enable_in = 1'b1;
                mc_data_in          = memWord(pendingAddr);
                resultLegit         = 1'b1;
                resultAddr          = pendingAddr;
            end
        end
    endtask

    task automatic doClear(input logic [31:0] target);
        clear_flag_in = 1'b1;
        clear_pc_in   = target;
        step();
        clear_flag_in = 1'b0;
    endtask

    task automatic runPushes(input int n, input int budget, output bit ok);
        int target = pushCount + n;
        int c = 0;
        while (pushCount < target && c < budget) begin
            step();
            c++;
        end
        ok = (pushCount >= target);
    endtask

    task automatic waitFetch(input int budget, output bit ok);
        int c = 0;
        ok = 1'b0;
        while (!ok && c < budget) begin
            step();
            c++;
            ok = (mc_fetch_enable_out === 1'b1);
        end
    endtask

    task automatic waitResult(input int budget, output bit ok);
        int c = 0;
        ok = 1'b0;
        while (!ok && c < budget) begin
            step();
            c++;
            ok = (mc_result_enable_in === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; clear_flag_in = 1'b0; clear_pc_in = '0;
        mc_result_enable_in = 1'b0; mc_data_in = '0; iq_full_in = 1'b0;
        modelReset();
        #12;
        checks++;
        if ({mc_fetch_enable_out, iq_enable_out} !== 2'b00 || mc_addr_out !== 32'd0
            || iq_inst_out !== 32'd0 || iq_pc_out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got fetch=%b addr=%h push=%b inst=%h pc=%h expected all 0",
                     mc_fetch_enable_out, mc_addr_out, iq_enable_out, iq_inst_out, iq_pc_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mc_fetch_enable_out !== 1'b0 || iq_enable_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rdy_low_idle: got fetch=%b push=%b expected 0 0", mc_fetch_enable_out, iq_enable_out);
            end
        end
    endtask

    task automatic test_cold_fetch();
        bit ok;
        int r0 = reqCount;
        rdy = 1'b1;
        fixedLat = 5;
        runPushes(1, 40, ok);
        fixedLat = 0;
        checks++;
        if (ok !== 1'b1 || reqCount - r0 !== 1) begin
            failures++;
            $display("[TB] FAIL cold_fetch: got pushed=%b requests=%0d expected 1 1", ok, reqCount - r0);
        end
        step();
        checks++;
        if (mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'd4) begin
            failures++;
            $display("[TB] FAIL cold_next_pc: got fetch=%b addr=%h expected 1 00000004", mc_fetch_enable_out, mc_addr_out);
        end
    endtask

    task automatic test_warm_loop();
        bit ok;
        doClear(32'd0);
        runPushes(3, 100, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL warm_fill: got timeout expected 3 pushes");
        end
        doClear(32'd0);
`ifdef ICACHE_EN
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (iq_enable_out !== 1'b1 || mc_fetch_enable_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL warm_hit_%0d: got push=%b fetch=%b expected 1 0", i, iq_enable_out, mc_fetch_enable_out);
            end
        end
`else
        runPushes(3, 100, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL warm_refetch: got timeout expected 3 pushes");
        end
`endif
    endtask

    task automatic test_conflict();
        bit ok;
        bit allOk = 1'b1;
        int r0;
        doClear(32'h200);
        runPushes(1, 40, ok);
        allOk &= ok;
        r0 = reqCount;
        doClear(32'h000); runPushes(1, 40, ok); allOk &= ok;
        doClear(32'h100); runPushes(1, 40, ok); allOk &= ok;
        doClear(32'h000); runPushes(1, 40, ok); allOk &= ok;
        checks++;
        if (allOk !== 1'b1 || reqCount - r0 !== 3) begin
            failures++;
            $display("[TB] FAIL conflict_requests: got ok=%b requests=%0d expected 1 3", allOk, reqCount - r0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        doClear(32'h40);
        waitResult(40, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_result_timeout: got no result expected one");
        end
        iq_full_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (iq_enable_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold_%0d: got push=%b expected 0", i, iq_enable_out);
            end
        end
        iq_full_in = 1'b0;
        step();
        checks++;
        if (iq_enable_out !== 1'b1 || iq_pc_out !== 32'h40) begin
            failures++;
            $display("[TB] FAIL bp_release: got push=%b pc=%h expected 1 00000040", iq_enable_out, iq_pc_out);
        end
    endtask

    task automatic test_clear_wait();
        bit ok;
        int r0;
        doClear(32'h60);
        waitFetch(10, ok);
        pendingCnt = 0;
        step();
        step();
        clear_flag_in       = 1'b1;
        clear_pc_in         = 32'h80;
        mc_result_enable_in = 1'b1;
        mc_data_in          = 32'hDEAD_BEEF;
        staleHold           = 1'b1;
        resultLegit         = 1'b0;
        step();
        clear_flag_in = 1'b0;
        step();
        checks++;
        if (ok !== 1'b1 || mc_fetch_enable_out !== 1'b1 || mc_addr_out !== 32'h80) begin
            failures++;
            $display("[TB] FAIL clear_wait_refetch: got fetch=%b addr=%h expected 1 00000080", mc_fetch_enable_out, mc_addr_out);
        end
        runPushes(1, 40, ok);
        r0 = reqCount;
        doClear(32'h60);
        runPushes(1, 40, ok);
        checks++;
        if (ok !== 1'b1 || reqCount - r0 !== 1) begin
            failures++;
            $display("[TB] FAIL stale_not_cached: got ok=%b requests=%0d expected 1 1", ok, reqCount - r0);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        doClear(32'hFFFF_FFF8);
        runPushes(3, 100, ok);
        checks++;
        if (ok !== 1'b1 || iq_pc_out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL pc_wrap: got ok=%b last pc=%h expected 1 00000000", ok, iq_pc_out);
        end
    endtask

    task automatic test_rdy_freeze();
        bit ok;
        doClear(32'hA0);
        waitResult(40, ok);
        step();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (iq_enable_out !== 1'b0 || mc_fetch_enable_out !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rdy_freeze_%0d: got push=%b fetch=%b expected 0 0", i, iq_enable_out, mc_fetch_enable_out);
            end
        end
        rdy = 1'b1;
        step();
        checks++;
        if (ok !== 1'b1 || iq_enable_out !== 1'b1 || iq_pc_out !== 32'hA0) begin
            failures++;
            $display("[TB] FAIL rdy_resume: got push=%b pc=%h expected 1 000000a0", iq_enable_out, iq_pc_out);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        doClear(32'hC0);
        waitResult(40, ok);
        iq_full_in = 1'b1;
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mc_fetch_enable_out, iq_enable_out} !== 2'b00 || mc_addr_out !== 32'd0
            || iq_inst_out !== 32'd0 || iq_pc_out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got addr=%h inst=%h pc=%h expected all 0", mc_addr_out, iq_inst_out, iq_pc_out);
        end
        modelReset();
        mc_result_enable_in = 1'b0;
        iq_full_in = 1'b0;
        #2 rst = 1'b0;
        waitFetch(10, ok);
        checks++;
        if (ok !== 1'b1 || mc_addr_out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL post_reset_fetch: got ok=%b addr=%h expected 1 00000000", ok, mc_addr_out);
        end
    endtask

    task automatic test_random();
        int p0 = pushCount;
        logic [31:0] target;
        for (int i = 0; i < 800; i++) begin
            iq_full_in = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 9) == 0) target = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
                else target = 32'($urandom_range(0, 95)) << 2;
                doClear(target);
            end else begin
                step();
            end
        end
        iq_full_in = 1'b0;
        checks++;
        if (pushCount - p0 < 20) begin
            failures++;
            $display("[TB] FAIL random_progress: got %0d pushes expected at least 20", pushCount - p0);
        end
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
        test_warm_loop();
        test_conflict();
        test_backpressure();
        test_clear_wait();
        test_wrap();
        test_rdy_freeze();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("[TB] FAIL watchdog: got no completion expected finish before 300000ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
